// File: rtl/axi_gp_reg_slave.sv
// AXI3 GP slave register bank with independent read/write FSMs
// and a registered fabric-side read port.
module axi_gp_reg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          REG_AW    = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    input  logic [11:0] ARID,
    input  logic [3:0]  ARLEN,
    input  logic [1:0]  ARSIZE,
    input  logic [1:0]  ARBURST,
    input  logic [1:0]  ARLOCK,
    input  logic [3:0]  ARCACHE,
    input  logic [2:0]  ARPROT,
    input  logic [3:0]  ARQOS,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic        RVALID,
    output logic [11:0] RID,
    output logic        RLAST,
    output logic [1:0]  RRESP,
    input  logic        RREADY,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    input  logic [11:0] AWID,
    input  logic [3:0]  AWLEN,
    input  logic [1:0]  AWSIZE,
    input  logic [1:0]  AWBURST,
    input  logic [1:0]  AWLOCK,
    input  logic [3:0]  AWCACHE,
    input  logic [2:0]  AWPROT,
    input  logic [3:0]  AWQOS,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    input  logic [11:0] WID,
    input  logic        WLAST,
    input  logic [3:0]  WSTRB,
    output logic        WREADY,
    output logic        BVALID,
    output logic [11:0] BID,
    output logic [1:0]  BRESP,
    input  logic        BREADY,
    input  logic [REG_AW-1:0] usr_raddr,
    output logic [31:0] usr_rdata
);

    localparam int          NREG = 1 << REG_AW;
    localparam logic [31:0] SPAN = 32'(4 * NREG);

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_DATA = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_SLV = 2'b10;

    logic [31:0] r_regs [NREG];

    logic [31:0]       w_aw_off;
    logic [31:0]       w_ar_off;
    logic              w_aw_err;
    logic              w_ar_err;
    logic [REG_AW-1:0] w_aw_idx;
    logic [REG_AW-1:0] w_ar_idx;

    assign w_aw_off = AWADDR - BASE_ADDR;
    assign w_ar_off = ARADDR - BASE_ADDR;
    assign w_aw_idx = w_aw_off[REG_AW+1:2];
    assign w_ar_idx = w_ar_off[REG_AW+1:2];
    assign w_aw_err = (w_aw_off >= SPAN) || (AWSIZE != 2'b10)
                   || (AWBURST == 2'b11);
    assign w_ar_err = (w_ar_off >= SPAN) || (ARSIZE != 2'b10)
                   || (ARBURST == 2'b11);

    logic w_unused;
    assign w_unused = ^{ARLOCK, ARCACHE, ARPROT, ARQOS,
                        AWLOCK, AWCACHE, AWPROT, AWQOS, WID};

    // ---------------- write channel ----------------
    logic [1:0]        r_wr_state;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [11:0]       r_bid;
    logic [1:0]        r_bresp;
    logic [REG_AW-1:0] r_wr_idx;
    logic [3:0]        r_wr_len;
    logic [3:0]        r_wr_cnt;
    logic              r_wr_fixed;
    logic              r_wr_err;
    logic              r_wlast_err;

    logic w_w_hs;
    logic w_w_last;
    logic w_w_lasterr;

    assign w_w_hs      = WVALID && r_wready;
    assign w_w_last    = (r_wr_cnt == r_wr_len);
    assign w_w_lasterr = (WLAST != w_w_last);

    always_ff @(posedge ACLK or posedge ARESETN) begin
        if (ARESETN) begin
            r_wr_state  <= WR_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= RESP_OK;
            r_wr_idx    <= '0;
            r_wr_len    <= '0;
            r_wr_cnt    <= '0;
            r_wr_fixed  <= 1'b0;
            r_wr_err    <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            unique case (r_wr_state)
                WR_IDLE: begin
                    if (AWVALID && r_awready) begin
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_bid       <= AWID;
                        r_wr_idx    <= w_aw_idx;
                        r_wr_len    <= AWLEN;
                        r_wr_cnt    <= '0;
                        r_wr_fixed  <= (AWBURST == 2'b00);
                        r_wr_err    <= w_aw_err;
                        r_wlast_err <= 1'b0;
                        r_wr_state  <= WR_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_w_hs) begin
                        r_wr_cnt <= r_wr_cnt + 4'd1;
                        if (!r_wr_fixed)
                            r_wr_idx <= r_wr_idx + 1'b1;
                        if (w_w_lasterr)
                            r_wlast_err <= 1'b1;
                        if (w_w_last) begin
                            r_wready   <= 1'b0;
                            r_bvalid   <= 1'b1;
                            r_bresp    <= (r_wr_err || r_wlast_err
                                        || w_w_lasterr)
                                        ? RESP_SLV : RESP_OK;
                            r_wr_state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    // Reads in the same cycle sample the pre-write contents.
    always_ff @(posedge ACLK or posedge ARESETN) begin
        if (ARESETN) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_w_hs && !r_wr_err) begin
            for (int b = 0; b < 4; b++)
                if (WSTRB[b])
                    r_regs[r_wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
        end
    end

    logic [31:0] r_usr_rdata;

    always_ff @(posedge ACLK or posedge ARESETN) begin
        if (ARESETN)
            r_usr_rdata <= '0;
        else
            r_usr_rdata <= r_regs[usr_raddr];
    end

    // ---------------- read channel ----------------
    logic [0:0]        r_rd_state;
    logic              r_arready;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [11:0]       r_rid;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic [REG_AW-1:0] r_rd_idx;
    logic [3:0]        r_rd_len;
    logic [3:0]        r_rd_cnt;
    logic              r_rd_fixed;
    logic              r_rd_err;

    logic [REG_AW-1:0] w_rd_nidx;
    logic [3:0]        w_rd_ncnt;

    assign w_rd_nidx = r_rd_fixed ? r_rd_idx : r_rd_idx + 1'b1;
    assign w_rd_ncnt = r_rd_cnt + 4'd1;

    always_ff @(posedge ACLK or posedge ARESETN) begin
        if (ARESETN) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rid      <= '0;
            r_rresp    <= RESP_OK;
            r_rlast    <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_len   <= '0;
            r_rd_cnt   <= '0;
            r_rd_fixed <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            unique case (r_rd_state)
                RD_IDLE: begin
                    if (ARVALID && r_arready) begin
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rid      <= ARID;
                        r_rresp    <= w_ar_err ? RESP_SLV : RESP_OK;
                        r_rdata    <= w_ar_err ? '0 : r_regs[w_ar_idx];
                        r_rlast    <= (ARLEN == 4'd0);
                        r_rd_idx   <= w_ar_idx;
                        r_rd_len   <= ARLEN;
                        r_rd_cnt   <= '0;
                        r_rd_fixed <= (ARBURST == 2'b00);
                        r_rd_err   <= w_ar_err;
                        r_rd_state <= RD_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        if (r_rlast) begin
                            r_rvalid   <= 1'b0;
                            r_rlast    <= 1'b0;
                            r_arready  <= 1'b1;
                            r_rd_state <= RD_IDLE;
                        end else begin
                            r_rd_idx <= w_rd_nidx;
                            r_rd_cnt <= w_rd_ncnt;
                            r_rdata  <= r_rd_err ? '0 : r_regs[w_rd_nidx];
                            r_rlast  <= (w_rd_ncnt == r_rd_len);
                        end
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_wready;
    assign BVALID    = r_bvalid;
    assign BID       = r_bid;
    assign BRESP     = r_bresp;
    assign ARREADY   = r_arready;
    assign RVALID    = r_rvalid;
    assign RDATA     = r_rdata;
    assign RID       = r_rid;
    assign RRESP     = r_rresp;
    assign RLAST     = r_rlast;
    assign usr_rdata = r_usr_rdata;

endmodule

// File: tb/tb_axi_gp_reg_slave.sv
// Directed bench for axi_gp_reg_slave: single, strobe, wrap,
// error, backpressure, concurrency and mid-burst reset scenarios.
module tb_axi_gp_reg_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic [11:0] ARID;
    logic [3:0]  ARLEN;
    logic [1:0]  ARSIZE, ARBURST, ARLOCK;
    logic [3:0]  ARCACHE, ARQOS;
    logic [2:0]  ARPROT;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RVALID, RLAST, RREADY;
    logic [11:0] RID;
    logic [1:0]  RRESP;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic [11:0] AWID;
    logic [3:0]  AWLEN;
    logic [1:0]  AWSIZE, AWBURST, AWLOCK;
    logic [3:0]  AWCACHE, AWQOS;
    logic [2:0]  AWPROT;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID, WLAST, WREADY;
    logic [11:0] WID;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [11:0] BID;
    logic [1:0]  BRESP;
    logic [3:0]  usr_raddr;
    logic [31:0] usr_rdata;

    int total = 0;
    int bad = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [11:0] rd_id;

    always #5 ACLK = ~ACLK;

    axi_gp_reg_slave #(.BASE_ADDR(32'h0), .REG_AW(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARID(ARID),
        .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARQOS(ARQOS), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RID(RID),
        .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWID(AWID),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWQOS(AWQOS), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WID(WID),
        .WLAST(WLAST), .WSTRB(WSTRB), .WREADY(WREADY),
        .BVALID(BVALID), .BID(BID), .BRESP(BRESP),
        .BREADY(BREADY),
        .usr_raddr(usr_raddr), .usr_rdata(usr_rdata)
    );

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_write(
        input  logic [31:0] addr, input logic [3:0] len,
        input  logic [1:0] size, input logic [1:0] burst,
        input  logic [11:0] id, input logic [3:0] strb,
        input  bit bad_last, input int bdelay,
        output logic [1:0] bresp, output logic [11:0] bid,
        output bit held);
        int n;
        AWADDR = addr; AWLEN = len; AWSIZE = size;
        AWBURST = burst; AWID = id; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL aw_timeout got AWREADY=%b want 1", AWREADY);
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wr_data[i]; WSTRB = strb; WVALID = 1'b1;
            WLAST = (i == int'(len)) && !bad_last;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) begin
                total++; bad++;
                $display("FAIL w_timeout got WREADY=%b want 1", WREADY);
            end
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL b_timeout got BVALID=%b want 1", BVALID);
        end
        bresp = BRESP; bid = BID; held = 1'b1;
        repeat (bdelay) begin
            @(negedge ACLK);
            if (BVALID !== 1'b1 || BRESP !== bresp || BID !== bid)
                held = 1'b0;
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic do_read(
        input  logic [31:0] addr, input logic [3:0] len,
        input  logic [1:0] size, input logic [1:0] burst,
        input  logic [11:0] id, input int stall,
        output bit stable, output int cycles);
        int n;
        int beats;
        logic [31:0] snap;
        ARADDR = addr; ARLEN = len; ARSIZE = size;
        ARBURST = burst; ARID = id; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL ar_timeout got ARREADY=%b want 1", ARREADY);
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        snap = RDATA; stable = RVALID;
        repeat (stall) begin
            @(negedge ACLK);
            if (RVALID !== 1'b1 || RDATA !== snap) stable = 1'b0;
        end
        RREADY = 1'b1; beats = 0; cycles = 0;
        while (beats <= int'(len) && cycles < 100) begin
            if (RVALID) begin
                rd_data[beats] = RDATA; rd_last[beats] = RLAST;
                rd_resp[beats] = RRESP; rd_id = RID;
                beats++;
            end
            @(negedge ACLK);
            cycles++;
        end
        RREADY = 1'b0;
        if (beats <= int'(len)) begin
            total++; bad++;
            $display("FAIL r_timeout got beats=%0d want %0d",
                     beats, int'(len) + 1);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({ARREADY, AWREADY, WREADY, RVALID, BVALID, RLAST} !== 6'b0)
        begin
            bad++;
            $display("FAIL rst_ctrl got %b want 000000",
                     {ARREADY, AWREADY, WREADY, RVALID, BVALID, RLAST});
        end
        total++;
        if ({RDATA, RID, RRESP, BID, BRESP, usr_rdata} !== '0) begin
            bad++;
            $display("FAIL rst_data got %h/%h/%h/%h/%h/%h want 0",
                     RDATA, RID, RRESP, BID, BRESP, usr_rdata);
        end
        ARESETN = 1'b0;
        @(negedge ACLK);
        total++;
        if ({ARREADY, AWREADY} !== 2'b11) begin
            bad++;
            $display("FAIL rst_ready got %b want 11", {ARREADY, AWREADY});
        end
    endtask

    task automatic test_single;
        logic [1:0] br; logic [11:0] bi; bit h, st; int cy;
        wr_data[0] = 32'h1234_5678;
        do_write(32'h4, 4'd0, 2'd2, 2'd1, 12'h005, 4'hF, 0, 0, br, bi, h);
        total++;
        if (br !== 2'b00 || bi !== 12'h005) begin
            bad++;
            $display("FAIL single_b got %b/%h want 00/005", br, bi);
        end
        do_read(32'h4, 4'd0, 2'd2, 2'd1, 12'h005, 0, st, cy);
        total++;
        if (rd_data[0] !== 32'h1234_5678 || rd_last[0] !== 1'b1
            || rd_resp[0] !== 2'b00 || rd_id !== 12'h005) begin
            bad++;
            $display("FAIL single_r got %h/%b/%b/%h want 12345678/1/00/005",
                     rd_data[0], rd_last[0], rd_resp[0], rd_id);
        end
        total++;
        if (ARREADY !== 1'b1) begin
            bad++;
            $display("FAIL single_arready got %b want 1", ARREADY);
        end
        usr_raddr = 4'd1;
        @(negedge ACLK); @(negedge ACLK);
        total++;
        if (usr_rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL single_usr got %h want 12345678", usr_rdata);
        end
    endtask

    task automatic test_strobe;
        logic [1:0] br; logic [11:0] bi; bit h, st; int cy;
        wr_data[0] = 32'hAABB_CCDD;
        do_write(32'h4, 4'd0, 2'd2, 2'd1, 12'h001, 4'h5, 0, 0, br, bi, h);
        do_read(32'h4, 4'd0, 2'd2, 2'd1, 12'h001, 0, st, cy);
        total++;
        if (rd_data[0] !== 32'h12BB_56DD) begin
            bad++;
            $display("FAIL strobe got %h want 12bb56dd", rd_data[0]);
        end
    endtask

    task automatic test_wrap;
        logic [1:0] br; logic [11:0] bi; bit h, st; int cy;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
        do_write(32'h38, 4'd3, 2'd2, 2'd1, 12'h00E, 4'hF, 0, 0, br, bi, h);
        total++;
        if (br !== 2'b00) begin
            bad++;
            $display("FAIL wrap_b got %b want 00", br);
        end
        do_read(32'h38, 4'd3, 2'd2, 2'd1, 12'h00E, 0, st, cy);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL wrap_r%0d got %h/%b want %h/%b", i,
                         rd_data[i], rd_last[i], i + 1, i == 3);
            end
        end
        usr_raddr = 4'd0;
        @(negedge ACLK); @(negedge ACLK);
        total++;
        if (usr_rdata !== 32'd3) begin
            bad++;
            $display("FAIL wrap_usr0 got %h want 3", usr_rdata);
        end
    endtask

    task automatic test_errors;
        logic [1:0] br; logic [11:0] bi; bit h, st; int cy;
        wr_data[0] = 32'hDEAD_BEEF;
        do_write(32'h40, 4'd0, 2'd2, 2'd1, 12'h002, 4'hF, 0, 0, br, bi, h);
        total++;
        if (br !== 2'b10) begin
            bad++;
            $display("FAIL range_b got %b want 10", br);
        end
        usr_raddr = 4'd0;
        @(negedge ACLK); @(negedge ACLK);
        total++;
        if (usr_rdata !== 32'd3) begin
            bad++;
            $display("FAIL range_nowrite got %h want 3", usr_rdata);
        end
        do_read(32'h38, 4'd1, 2'd0, 2'd1, 12'h003, 0, st, cy);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10) begin
                bad++;
                $display("FAIL size_r%0d got %h/%b want 0/10",
                         i, rd_data[i], rd_resp[i]);
            end
        end
        wr_data[0] = 32'h55; wr_data[1] = 32'h66;
        do_write(32'h8, 4'd1, 2'd2, 2'd1, 12'h004, 4'hF, 1, 0, br, bi, h);
        total++;
        if (br !== 2'b10) begin
            bad++;
            $display("FAIL wlast_b got %b want 10", br);
        end
        do_read(32'h8, 4'd1, 2'd2, 2'd1, 12'h004, 0, st, cy);
        total++;
        if (rd_data[0] !== 32'h55 || rd_data[1] !== 32'h66) begin
            bad++;
            $display("FAIL wlast_data got %h,%h want 55,66",
                     rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_backpressure;
        bit st; int cy;
        do_read(32'h38, 4'd2, 2'd2, 2'd1, 12'h007, 5, st, cy);
        total++;
        if (st !== 1'b1 || cy != 3) begin
            bad++;
            $display("FAIL bp_timing got stable=%b cycles=%0d want 1/3",
                     st, cy);
        end
        total++;
        if (rd_data[0] !== 32'd1 || rd_data[1] !== 32'd2
            || rd_data[2] !== 32'd3) begin
            bad++;
            $display("FAIL bp_data got %h,%h,%h want 1,2,3",
                     rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    task automatic test_concurrent;
        logic [1:0] br; logic [11:0] bi; bit h, st; int cy;
        wr_data[0] = 32'hA0; wr_data[1] = 32'hB1; wr_data[2] = 32'hC2;
        fork
            do_write(32'h10, 4'd2, 2'd2, 2'd1, 12'h0AB, 4'hF, 0, 4,
                     br, bi, h);
            do_read(32'h38, 4'd2, 2'd2, 2'd1, 12'h0CD, 0, st, cy);
        join
        total++;
        if (br !== 2'b00 || bi !== 12'h0AB || h !== 1'b1) begin
            bad++;
            $display("FAIL conc_b got %b/%h/held=%b want 00/0ab/1",
                     br, bi, h);
        end
        total++;
        if (rd_data[0] !== 32'd1 || rd_data[1] !== 32'd2
            || rd_data[2] !== 32'd3 || rd_id !== 12'h0CD) begin
            bad++;
            $display("FAIL conc_r got %h,%h,%h/%h want 1,2,3/0cd",
                     rd_data[0], rd_data[1], rd_data[2], rd_id);
        end
        do_read(32'h10, 4'd2, 2'd2, 2'd1, 12'h0AB, 0, st, cy);
        total++;
        if (rd_data[0] !== 32'hA0 || rd_data[1] !== 32'hB1
            || rd_data[2] !== 32'hC2) begin
            bad++;
            $display("FAIL conc_wdata got %h,%h,%h want a0,b1,c2",
                     rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    task automatic test_mid_reset;
        logic [1:0] br; logic [11:0] bi; bit h, st; int cy; int n;
        AWADDR = 32'h0; AWLEN = 4'd3; AWSIZE = 2'd2; AWBURST = 2'd1;
        AWID = 12'h009; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        AWVALID = 1'b0;
        WDATA = 32'h1111_1111; WSTRB = 4'hF; WLAST = 1'b0;
        WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        ARESETN = 1'b1;
        #1;
        total++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, BID, BRESP}
            !== '0) begin
            bad++;
            $display("FAIL mrst_out got %b%b%b%b%b/%h/%b want 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, BID, BRESP);
        end
        @(negedge ACLK);
        ARESETN = 1'b0;
        usr_raddr = 4'd0;
        @(negedge ACLK); @(negedge ACLK);
        total++;
        if (usr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL mrst_reg0 got %h want 0", usr_rdata);
        end
        usr_raddr = 4'd14;
        @(negedge ACLK); @(negedge ACLK);
        total++;
        if (usr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL mrst_reg14 got %h want 0", usr_rdata);
        end
        wr_data[0] = 32'hCAFE_F00D;
        do_write(32'h0, 4'd0, 2'd2, 2'd1, 12'h00A, 4'hF, 0, 0, br, bi, h);
        do_read(32'h0, 4'd0, 2'd2, 2'd1, 12'h00A, 0, st, cy);
        total++;
        if (br !== 2'b00 || rd_data[0] !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL mrst_post got %b/%h want 00/cafef00d",
                     br, rd_data[0]);
        end
    endtask

    initial begin
        ARESETN = 1'b1;
        ARADDR = '0; ARVALID = 0; ARID = '0; ARLEN = '0;
        ARSIZE = '0; ARBURST = '0; ARLOCK = '0; ARCACHE = '0;
        ARPROT = '0; ARQOS = '0; RREADY = 0;
        AWADDR = '0; AWVALID = 0; AWID = '0; AWLEN = '0;
        AWSIZE = '0; AWBURST = '0; AWLOCK = '0; AWCACHE = '0;
        AWPROT = '0; AWQOS = '0;
        WDATA = '0; WVALID = 0; WID = '0; WLAST = 0; WSTRB = '0;
        BREADY = 0; usr_raddr = '0;
        repeat (3) @(negedge ACLK);
        test_reset;
        test_single;
        test_strobe;
        test_wrap;
        test_errors;
        test_backpressure;
        test_concurrent;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_gp_reg_slave.md
# axi_gp_reg_slave

AXI3 slave register file on the PS Master GP1 port: accepts single and burst reads/writes from the PS and holds a bank of 32-bit control/status registers. Write and read channels run independent state machines and may proceed concurrently. A one-cycle-latency fabric read port exposes register contents to PL logic.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of register 0
- REG_AW, 4, log2 of register count (16 words)
- ACLK  in  1  clock
- ARESETN  in  1  reset ARESETN, asynchronous, active-high; clock ACLK
- ARADDR/ARVALID/ARID/ARLEN/ARSIZE/ARBURST  in  32/1/12/4/2/2  read address; ARLOCK/ARCACHE/ARPROT/ARQOS in, ignored
- ARREADY  out  1  read address accept
- RDATA/RVALID/RID/RLAST/RRESP  out  32/1/12/1/2  read data
- RREADY  in  1  read data accept
- AWADDR/AWVALID/AWID/AWLEN/AWSIZE/AWBURST  in  32/1/12/4/2/2  write address; AWLOCK/AWCACHE/AWPROT/AWQOS in, ignored
- AWREADY  out  1  write address accept
- WDATA/WVALID/WID/WLAST/WSTRB  in  32/1/12/1/4  write data; WID ignored
- WREADY  out  1  write data accept
- BVALID/BID/BRESP  out  1/12/2  write response
- BREADY  in  1  response accept
- usr_raddr  in  REG_AW  fabric read index
- usr_rdata  out  32  register[usr_raddr], registered

## Operation
- Register file: 2^REG_AW x 32 bits, all cleared to 0 by reset. Word index = (addr - BASE_ADDR) >> 2, REG_AW bits.
- In range: (addr - BASE_ADDR) < 4*2^REG_AW, checked once on the start address. Out of range -> whole burst errors.
- Error (SLVERR = 2'b10) when: out of range, SIZE != 2'b10, or BURST = 2'b11. Otherwise OKAY (2'b00).
- Burst addressing:
  - FIXED (00): same index every beat.
  - INCR (01) and WRAP (10): index +1 per beat, modulo 2^REG_AW, so the last register wraps to index 0.
- Beats per burst = LEN + 1 (1..16).
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE:
  - WR_IDLE: AWREADY=1. An AW handshake latches AWID, start index, LEN, BURST and the error flag, then enters WR_DATA.
  - WR_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB (byte i = WDATA[8i+7:8i]); nothing is written on an error burst. The beat counter ends the burst on beat LEN+1, then the FSM enters WR_RESP.
  - WLAST mismatch (WLAST=1 on an earlier beat, or 0 on the final beat): BRESP=SLVERR. Writes are still performed and the burst length is still taken from the counter.
  - WR_RESP: BVALID=1, BID = latched AWID. On the BREADY handshake the FSM returns to WR_IDLE.
- Read FSM RD_IDLE -> RD_DATA -> RD_IDLE:
  - RD_IDLE: ARREADY=1. An AR handshake latches its fields and loads beat 0 into the output registers.
  - RD_DATA: RVALID=1, RID = latched ARID, RRESP per burst, RLAST=1 on beat LEN+1 only. RDATA = register[index], or 0 on error. On each RVALID&&RREADY the next beat is loaded in the same edge; after the last beat the FSM returns to RD_IDLE.
- Read/write collision on the same register in the same cycle: the read returns the old value; the new value is visible from the next cycle.
- usr_rdata = register[usr_raddr] sampled every cycle; it reflects a write one cycle after the W handshake edge.

## Timing
- Reset values: ARREADY=0, AWREADY=0, WREADY=0, RVALID=0, BVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=0, BID=0, BRESP=0, usr_rdata=0, both FSMs in IDLE.
- First cycle after reset deasserts: ARREADY=1, AWREADY=1.
- Reset asserted mid-burst aborts immediately: outputs return to reset values and registers clear. There is no completion response.
- All outputs are registered.
- Read latency: AR handshake at edge N -> RVALID=1 after edge N. With RREADY held high, one beat per cycle.
- After the final R handshake, ARREADY=1 on the following cycle. Minimum 1 idle cycle between bursts.
- Write: AW handshake at edge N -> WREADY=1 after N. With WVALID held high, one beat per cycle. The final W handshake at edge M -> BVALID=1 after M.
- After the B handshake, AWREADY=1 on the following cycle.
- Stalls: RVALID and RDATA/RID/RLAST/RRESP hold stable while RREADY=0. BVALID/BID/BRESP hold stable while BREADY=0.
- ARREADY and AWREADY are 0 outside IDLE. No outstanding transactions beyond one per direction.

## Test plan
- Single write then read: AW 0x4, SIZE 2, LEN 0, INCR, WDATA 0x12345678, WSTRB 0xF, ID 0x005. Expect B OKAY, BID 0x005. Then read 0x4 -> RDATA 0x12345678, RLAST=1, RRESP 00; usr_raddr=1 gives 0x12345678.
- Byte strobe: write 0xAABBCCDD with WSTRB 0x5 to a register holding 0x12345678. Expect readback 0x12BB56DD.
- INCR wrap: write 4 beats 1,2,3,4 at 0x38 (index 14). Expect index 14=1, 15=2, 0=3, 1=4; read burst LEN 3 at 0x38 returns 1,2,3,4 with RLAST on beat 4 only.
- Errors:
  - Write to BASE_ADDR+0x40 -> BRESP 10, no register changes.
  - Read with SIZE 0 -> RDATA 0, RRESP 10 for every beat.
  - WLAST=0 on the final beat -> BRESP 10.
- Backpressure and concurrency:
  - Read LEN 2 with RREADY low for 5 cycles -> first beat held stable, then 3 consecutive beats.
  - Write LEN 2 issued concurrently -> BVALID held until BREADY, with no interference between channels.
- Reset mid write burst after beat 1 -> all outputs 0, register cleared. Post-reset write/read to 0x0 works normally.
